// File: rtl/pkg_en.sv
// Shared definitions for the ElectronNest compute node.
// Holds the data/address widths, the forward/backward token structs,
// the element-wise op encoding and the top-level FSM state type.
package pkg_en;

   localparam int WIDTH_DATA   = 32;
   localparam int WIDTH_EXADDR = 32;

   // Forward token: valid, acquire, release, condition, [index], data.
   typedef struct packed {
      logic                    v;
      logic                    a;
      logic                    r;
      logic                    c;
`ifdef EXTEND_MEM
      logic [WIDTH_EXADDR-1:0] i;
`endif
      logic [WIDTH_DATA-1:0]   d;
   } FTk_t;

   // Backward token: nack, term, valid, condition.
   typedef struct packed {
      logic n;
      logic t;
      logic v;
      logic c;
   } BTk_t;

   localparam logic [1:0] OP_COPY = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NEG  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOOT,
      S_LD_REQ,
      S_LD_WAIT,
      S_ST
   } state_t;

endpackage

// File: rtl/en_boot_cfg.sv
// Boot word counter and configuration register file.
// Ports:
//   clock, reset     system clock, async active-low reset
//   start            boot word 0 accepted this cycle
//   word_vld         a further boot word accepted this cycle
//   word             boot word payload
//   done             pulses with the acceptance of boot word 7
//   cfg0..cfg4       load base, store base, count, strides, op/imm
module en_boot_cfg
   import pkg_en::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  word_vld,
   input  logic [WIDTH_DATA-1:0] word,
   output logic                  done,
   output logic [WIDTH_DATA-1:0] cfg0,
   output logic [WIDTH_DATA-1:0] cfg1,
   output logic [WIDTH_DATA-1:0] cfg2,
   output logic [WIDTH_DATA-1:0] cfg3,
   output logic [WIDTH_DATA-1:0] cfg4
);

   // Index of the next boot word expected; word 0 arrives via start.
   logic [2:0] word_idx;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_idx <= '0;
         cfg0     <= '0;
         cfg1     <= '0;
         cfg2     <= '0;
         cfg3     <= '0;
         cfg4     <= '0;
      end else if (start) begin
         word_idx <= 3'd1;
      end else if (word_vld) begin
         // 3-bit index wraps to 0 after word 7, ready for the next boot.
         word_idx <= word_idx + 3'd1;
         case (word_idx)
            3'd3:    cfg0 <= word;
            3'd4:    cfg1 <= word;
            3'd5:    cfg2 <= word;
            3'd6:    cfg3 <= word;
            3'd7:    cfg4 <= word;
            default: ;
         endcase
      end
   end

   assign done = word_vld && (word_idx == 3'd7);

endmodule

// File: rtl/electron_nest.sv
// ElectronNest compute node: boot-configured load -> operate -> store engine.
// Ports:
//   clock, reset          system clock, async active-low reset
//   I_Boot                boot window; word 0 accepted only while high
//   O_Ld_Req/O_Ld_Addr    load request strobe and address
//   I_Ld_FTk              boot words and load data from memory
//   O_Ld_BTk              backpressure to the load side (n busy)
//   O_St_Req/O_St_Addr    store request strobe and address
//   O_St_FTk              store data token
//   I_St_BTk              store backpressure; n=1 stalls the store
module electron_nest
   import pkg_en::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    I_Boot,
   output logic                    O_Ld_Req,
   output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
   input  FTk_t                    I_Ld_FTk,
   output BTk_t                    O_Ld_BTk,
   output logic                    O_St_Req,
   output logic [WIDTH_EXADDR-1:0] O_St_Addr,
   output FTk_t                    O_St_FTk,
   input  BTk_t                    I_St_BTk
);

   state_t state, state_nxt;

   logic                         boot_start;
   logic                         boot_word;
   logic                         boot_done;
   logic                         st_commit;
   logic                         last_elem;
   logic [WIDTH_DATA-1:0]        cfg0, cfg1, cfg2, cfg3, cfg4;
   logic [WIDTH_DATA-1:0]        k;
   logic [WIDTH_EXADDR-1:0]      ld_off;
   logic [WIDTH_EXADDR-1:0]      st_off;
   logic signed [WIDTH_DATA-1:0] result_p0;
   logic                         unused_bits;

   function automatic logic signed [WIDTH_DATA-1:0] apply_op(
      input logic [1:0]                op,
      input logic signed [WIDTH_DATA-1:0] d,
      input logic [15:0]               imm
   );
      logic signed [WIDTH_DATA-1:0] imm_ext;
      imm_ext = {{(WIDTH_DATA-16){imm[15]}}, imm};
      case (op)
         OP_ADD:  apply_op = d + imm_ext;
         OP_XOR:  apply_op = d ^ imm_ext;
         OP_NEG:  apply_op = -d;
         default: apply_op = d;
      endcase
   endfunction

   assign boot_start = (state == S_IDLE) && I_Boot && I_Ld_FTk.v && I_Ld_FTk.a;
   assign boot_word  = (state == S_BOOT) && I_Ld_FTk.v;
   assign st_commit  = (state == S_ST) && !I_St_BTk.n;
   assign last_elem  = ((k + 32'd1) == cfg2);

   // Only v/a/d of the load token, n of the store token and op/imm of CFG4
   // steer the engine.
   assign unused_bits = ^{I_Ld_FTk, I_St_BTk, cfg4[15:2]};

   en_boot_cfg u_boot_cfg (
      .clock    (clock),
      .reset    (reset),
      .start    (boot_start),
      .word_vld (boot_word),
      .word     (I_Ld_FTk.d),
      .done     (boot_done),
      .cfg0     (cfg0),
      .cfg1     (cfg1),
      .cfg2     (cfg2),
      .cfg3     (cfg3),
      .cfg4     (cfg4)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      O_Ld_Req  = 1'b0;
      O_Ld_Addr = '0;
      O_Ld_BTk  = '0;
      O_St_Req  = 1'b0;
      O_St_Addr = '0;
      O_St_FTk  = '0;
      case (state)
         S_IDLE: begin
            if (boot_start) state_nxt = S_BOOT;
         end
         S_BOOT: begin
            if (boot_done) state_nxt = (cfg2 == '0) ? S_IDLE : S_LD_REQ;
         end
         S_LD_REQ: begin
            O_Ld_Req   = 1'b1;
            O_Ld_Addr  = cfg0 + ld_off;
            O_Ld_BTk.n = 1'b1;
            state_nxt  = S_LD_WAIT;
         end
         S_LD_WAIT: begin
            if (I_Ld_FTk.v) state_nxt = S_ST;
         end
         S_ST: begin
            O_St_Req   = 1'b1;
            O_St_Addr  = cfg1 + st_off;
            O_St_FTk.v = 1'b1;
            O_St_FTk.d = result_p0;
            O_Ld_BTk.n = 1'b1;
            if (st_commit) state_nxt = last_elem ? S_IDLE : S_LD_REQ;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Element index and address offsets advance once per committed store;
   // offsets accumulate the strides so no multiplier is needed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         k      <= '0;
         ld_off <= '0;
         st_off <= '0;
      end else if (boot_done) begin
         k      <= '0;
         ld_off <= '0;
         st_off <= '0;
      end else if (st_commit) begin
         k      <= k + 32'd1;
         ld_off <= ld_off + {{(WIDTH_EXADDR-16){1'b0}}, cfg3[15:0]};
         st_off <= st_off + {{(WIDTH_EXADDR-16){1'b0}}, cfg3[31:16]};
      end
   end

   // Stage p0: load data -> operated result, held through the store
   always_ff @(posedge clock) begin
      if ((state == S_LD_WAIT) && I_Ld_FTk.v)
         result_p0 <= apply_op(cfg4[1:0], signed'(I_Ld_FTk.d), cfg4[31:16]);
   end

endmodule

// File: tb/tb_electron_nest.sv
module tb_electron_nest;
   import pkg_en::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        I_Boot = 1'b0;
   logic        O_Ld_Req;
   logic [31:0] O_Ld_Addr;
   FTk_t        I_Ld_FTk;
   BTk_t        O_Ld_BTk;
   logic        O_St_Req;
   logic [31:0] O_St_Addr;
   FTk_t        O_St_FTk;
   BTk_t        I_St_BTk;

   FTk_t        boot_tok = '0;
   FTk_t        mem_tok  = '0;
   logic        st_n     = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] mem [0:1023];
   int          ld_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] first_ld_addr = '0;

   bit          stall_en  = 1'b0;
   int          stall_cnt = 0;
   int          stall_bad = 0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_d    = '0;

   always #5 clock = ~clock;

   assign I_Ld_FTk = FTk_t'(boot_tok | mem_tok);
   assign I_St_BTk = BTk_t'({st_n, 3'b000});

   electron_nest dut (
      .clock     (clock),
      .reset     (reset),
      .I_Boot    (I_Boot),
      .O_Ld_Req  (O_Ld_Req),
      .O_Ld_Addr (O_Ld_Addr),
      .I_Ld_FTk  (I_Ld_FTk),
      .O_Ld_BTk  (O_Ld_BTk),
      .O_St_Req  (O_St_Req),
      .O_St_Addr (O_St_Addr),
      .O_St_FTk  (O_St_FTk),
      .I_St_BTk  (I_St_BTk)
   );

   // Memory model: load data one cycle after the request, store on handshake.
   always @(posedge clock) begin
      mem_tok <= '0;
      if (O_Ld_Req) begin
         mem_tok.v <= 1'b1;
         mem_tok.d <= mem[O_Ld_Addr[9:0]];
         if (ld_cnt == 0) first_ld_addr = O_Ld_Addr;
         ld_cnt++;
      end
      if (O_St_Req && O_St_FTk.v && !st_n) begin
         mem[O_St_Addr[9:0]] = O_St_FTk.d;
         wr_cnt++;
      end
   end

   // Store backpressure: stall the second store for five cycles.
   always @(negedge clock) begin
      if (stall_en && O_St_Req && wr_cnt == 1 && stall_cnt < 5) begin
         if (stall_cnt == 0) begin
            hold_addr = O_St_Addr;
            hold_d    = O_St_FTk.d;
         end else if (O_St_Addr !== hold_addr || O_St_FTk.d !== hold_d) begin
            stall_bad++;
         end
         st_n = 1'b1;
         stall_cnt++;
      end else begin
         st_n = 1'b0;
      end
   end

   task automatic clear_stats();
      ld_cnt = 0;
      wr_cnt = 0;
   endtask

   task automatic load_src();
      for (int i = 0; i < 4; i++) mem[10'h100 + i] = 32'(i + 1);
      for (int i = 0; i < 8; i++) mem[10'h200 + i] = 32'h5555_5555;
   endtask

   // Drive one full 8-word boot stream; returns on the negedge after word 7.
   task automatic send_boot(input logic [31:0] c0, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3,
                            input logic [31:0] c4);
      logic [31:0] w [5];
      w = '{c0, c1, c2, c3, c4};
      @(negedge clock);
      I_Boot     = 1'b1;
      boot_tok   = '0;
      boot_tok.v = 1'b1;
      boot_tok.a = 1'b1;
      boot_tok.d = 32'hB007_0000;
      @(negedge clock);
      I_Boot     = 1'b0;
      boot_tok.a = 1'b0;
      boot_tok.d = 32'hAAAA_0001;
      @(negedge clock);
      boot_tok.d = 32'hAAAA_0002;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         boot_tok.d = w[i];
      end
      @(negedge clock);
      boot_tok = '0;
   endtask

   task automatic wait_writes(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (wr_cnt >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if ({O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ld_req=%b ld_addr=%h st_req=%b st_addr=%h st_tok=%h, expected all 0",
                  O_Ld_Req, O_Ld_Addr, O_St_Req, O_St_Addr, O_St_FTk);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_copy();
      bit ok;
      load_src();
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd4, 32'h0001_0001, 32'h0);
      n_tests++;
      if (O_Ld_Req !== 1'b1 || O_Ld_Addr !== 32'h100 || O_Ld_BTk.n !== 1'b1) begin
         n_fail++;
         $display("FAIL copy_first_ldreq: got req=%b addr=%h n=%b, expected req=1 addr=00000100 n=1",
                  O_Ld_Req, O_Ld_Addr, O_Ld_BTk.n);
      end
      wait_writes(4, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL copy_timeout: got %0d writes, expected 4", wr_cnt);
      end
      n_tests++;
      if (O_St_Req !== 1'b0) begin
         n_fail++;
         $display("FAIL copy_st_req_drop: got %b, expected 0", O_St_Req);
      end
      repeat (4) @(negedge clock);
      n_tests++;
      if (ld_cnt != 4 || wr_cnt != 4) begin
         n_fail++;
         $display("FAIL copy_counts: got ld=%0d st=%0d, expected ld=4 st=4", ld_cnt, wr_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mem[10'h200 + i] !== 32'(i + 1)) begin
            n_fail++;
            $display("FAIL copy_data[%0d]: got %h, expected %h", i, mem[10'h200 + i], 32'(i + 1));
         end
      end
   endtask

   task automatic test_add_imm();
      bit ok;
      load_src();
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd4, 32'h0001_0001, 32'hFFFF_0001);
      wait_writes(4, ok);
      repeat (4) @(negedge clock);
      n_tests++;
      if (!ok || wr_cnt != 4) begin
         n_fail++;
         $display("FAIL add_count: got %0d writes, expected 4", wr_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mem[10'h200 + i] !== 32'(i)) begin
            n_fail++;
            $display("FAIL add_data[%0d]: got %h, expected %h", i, mem[10'h200 + i], 32'(i));
         end
      end
   endtask

   task automatic test_neg_xor();
      bit          ok;
      logic [31:0] exp_neg [4];
      exp_neg = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
      load_src();
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd4, 32'h0001_0001, 32'h0000_0003);
      wait_writes(4, ok);
      repeat (4) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mem[10'h200 + i] !== exp_neg[i]) begin
            n_fail++;
            $display("FAIL neg_data[%0d]: got %h, expected %h", i, mem[10'h200 + i], exp_neg[i]);
         end
      end
      // imm 0x8000 sign-extends to 0xFFFF8000
      load_src();
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd1, 32'h0001_0001, 32'h8000_0002);
      wait_writes(1, ok);
      repeat (4) @(negedge clock);
      n_tests++;
      if (!ok || wr_cnt != 1 || mem[10'h200] !== 32'hFFFF_8001 || mem[10'h201] !== 32'h5555_5555) begin
         n_fail++;
         $display("FAIL xor_data: got %h (writes %0d), expected FFFF8001 (writes 1)", mem[10'h200], wr_cnt);
      end
   endtask

   task automatic test_strides();
      bit ok;
      load_src();
      mem[10'h100] = 32'hFFFF_FFFF;
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd3, 32'h0002_0000, 32'h0001_0001);
      wait_writes(3, ok);
      repeat (4) @(negedge clock);
      n_tests++;
      if (!ok || ld_cnt != 3 || wr_cnt != 3 || first_ld_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL stride_counts: got ld=%0d st=%0d first_ld=%h, expected ld=3 st=3 first_ld=00000100",
                  ld_cnt, wr_cnt, first_ld_addr);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (mem[10'h200 + 2 * i] !== 32'h0) begin
            n_fail++;
            $display("FAIL stride_data[%0d]: got %h, expected 00000000", 2 * i, mem[10'h200 + 2 * i]);
         end
      end
      n_tests++;
      if (mem[10'h201] !== 32'h5555_5555 || mem[10'h203] !== 32'h5555_5555) begin
         n_fail++;
         $display("FAIL stride_gap: got %h %h, expected 55555555 55555555", mem[10'h201], mem[10'h203]);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      load_src();
      clear_stats();
      stall_cnt = 0;
      stall_bad = 0;
      stall_en  = 1'b1;
      send_boot(32'h100, 32'h200, 32'd4, 32'h0001_0001, 32'h0);
      wait_writes(4, ok);
      repeat (4) @(negedge clock);
      stall_en = 1'b0;
      n_tests++;
      if (!ok || stall_cnt != 5 || stall_bad != 0) begin
         n_fail++;
         $display("FAIL bp_stall: got stalls=%0d unstable=%0d, expected stalls=5 unstable=0", stall_cnt, stall_bad);
      end
      n_tests++;
      if (wr_cnt != 4 || hold_addr !== 32'h201 || hold_d !== 32'h2) begin
         n_fail++;
         $display("FAIL bp_writes: got writes=%0d held addr=%h data=%h, expected 4 00000201 00000002",
                  wr_cnt, hold_addr, hold_d);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mem[10'h200 + i] !== 32'(i + 1)) begin
            n_fail++;
            $display("FAIL bp_data[%0d]: got %h, expected %h", i, mem[10'h200 + i], 32'(i + 1));
         end
      end
   endtask

   task automatic test_n_zero();
      bit ok;
      load_src();
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd0, 32'h0001_0001, 32'h0);
      repeat (10) @(negedge clock);
      n_tests++;
      if (ld_cnt != 0 || wr_cnt != 0 || O_Ld_BTk.n !== 1'b0) begin
         n_fail++;
         $display("FAIL nzero_idle: got ld=%0d st=%0d n=%b, expected 0 0 0", ld_cnt, wr_cnt, O_Ld_BTk.n);
      end
      send_boot(32'h100, 32'h200, 32'd2, 32'h0001_0001, 32'h0);
      wait_writes(2, ok);
      repeat (4) @(negedge clock);
      n_tests++;
      if (!ok || wr_cnt != 2 || mem[10'h200] !== 32'h1 || mem[10'h201] !== 32'h2) begin
         n_fail++;
         $display("FAIL nzero_reboot: got writes=%0d data=%h %h, expected 2 00000001 00000002",
                  wr_cnt, mem[10'h200], mem[10'h201]);
      end
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      load_src();
      for (int i = 0; i < 4; i++) mem[10'h300 + i] = 32'h0;
      clear_stats();
      send_boot(32'h100, 32'h200, 32'd4, 32'h0001_0001, 32'h0);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (O_St_Req && wr_cnt == 1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rst_reach_st2: got writes=%0d, expected second store pending", wr_cnt);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if ({O_Ld_Req, O_Ld_Addr, O_Ld_BTk, O_St_Req, O_St_Addr, O_St_FTk} !== '0) begin
         n_fail++;
         $display("FAIL rst_async_outputs: got ld_req=%b st_req=%b st_addr=%h st_tok=%h, expected all 0",
                  O_Ld_Req, O_St_Req, O_St_Addr, O_St_FTk);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      n_tests++;
      if (wr_cnt != 1) begin
         n_fail++;
         $display("FAIL rst_no_commit: got writes=%0d, expected 1", wr_cnt);
      end
      // Tokens without acquire must not start a boot.
      clear_stats();
      I_Boot     = 1'b1;
      boot_tok.v = 1'b1;
      boot_tok.d = 32'h0000_0004;
      repeat (9) @(negedge clock);
      I_Boot   = 1'b0;
      boot_tok = '0;
      repeat (4) @(negedge clock);
      n_tests++;
      if (ld_cnt != 0 || O_Ld_BTk.n !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ignore_no_a: got ld=%0d n=%b, expected 0 0", ld_cnt, O_Ld_BTk.n);
      end
      clear_stats();
      send_boot(32'h100, 32'h300, 32'd4, 32'h0001_0001, 32'h0);
      wait_writes(4, ok);
      repeat (4) @(negedge clock);
      n_tests++;
      if (!ok || wr_cnt != 4 || first_ld_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL rst_reboot: got writes=%0d first_ld=%h, expected 4 00000100", wr_cnt, first_ld_addr);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (mem[10'h300 + i] !== 32'(i + 1)) begin
            n_fail++;
            $display("FAIL rst_reboot_data[%0d]: got %h, expected %h", i, mem[10'h300 + i], 32'(i + 1));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      test_reset();
      test_copy();
      test_add_imm();
      test_neg_xor();
      test_strides();
      test_backpressure();
      test_n_zero();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/electron_nest.md
# electron_nest

Top-level compute node of the ElectronNest fabric, reduced to a single boot-configured load→operate→store streaming engine. The node is booted through its load port with a short configuration stream. It then reads a vector from external memory through the load request port, applies one element-wise operation, and writes the results back through the store port. External memory and its handshake sit outside the block; the testbench memory model is the reference environment.

## Interface
- WIDTH_DATA, 32, data word width (package constant)
- WIDTH_EXADDR, 32, external address width (package constant)
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- I_Boot  in  1  boot window; a boot stream may start only while high
- O_Ld_Req  out  1  load request strobe
- O_Ld_Addr  out  WIDTH_EXADDR  load address
- I_Ld_FTk  in  FTk_t  forward token from memory: v valid, a acquire, r release, c condition, d data
- O_Ld_BTk  out  BTk_t  backward token to memory: n nack, t term, v valid, c condition
- O_St_Req  out  1  store request strobe
- O_St_Addr  out  WIDTH_EXADDR  store address
- O_St_FTk  out  FTk_t  store data token
- I_St_BTk  in  BTk_t  store backpressure; n=1 stalls the store

## Operation
- States: IDLE, BOOT, LD_REQ, LD_WAIT, ST.
- In IDLE: a cycle with I_Boot & I_Ld_FTk.v & I_Ld_FTk.a counts as boot word 0 and enters BOOT. All other load tokens are ignored.
- In BOOT: each cycle with I_Ld_FTk.v counts one word, independent of I_Boot. Words 1–2 are header words and are discarded. Words 3–7 load config registers CFG0..CFG4.
- Config register map:
  - CFG0: load base address.
  - CFG1: store base address.
  - CFG2: element count N (unsigned).
  - CFG3: [15:0] load stride, [31:16] store stride (unsigned).
  - CFG4: [1:0] op, [31:16] imm (sign-extended).
- Op encoding: 00 copy; 01 d+imm; 10 d^imm; 11 −d. All arithmetic is WIDTH_DATA wide and wraps mod 2^32.
- After word 7: if N=0, go to IDLE. Otherwise set k=0 and go to LD_REQ.
- LD_REQ:
  - Drive O_Ld_Req=1 and O_Ld_Addr = CFG0 + k·ldstride for exactly one cycle.
  - Then go to LD_WAIT.
- LD_WAIT:
  - Wait for I_Ld_FTk.v. Latch f(d) into the result register.
  - Then go to ST.
- ST:
  - Drive O_St_Req=1, O_St_FTk.v=1, O_St_FTk.d=result, O_St_Addr = CFG1 + k·ststride.
  - Hold these outputs while I_St_BTk.n=1.
  - Once n=0, the store completes that cycle. Set k++. If k==N, go to IDLE; else go to LD_REQ.
- Address arithmetic wraps at WIDTH_EXADDR. A zero stride repeatedly hits the same address.
- O_Ld_BTk.n=1 in LD_REQ and ST; 0 otherwise. Its t, v and c bits are 0.
- O_St_FTk a, r, c and i are 0.
- Boot words arriving outside IDLE/BOOT are ignored. The a bit is ignored outside IDLE.

## Timing
- Reset: all outputs are 0, state is IDLE, config registers and k are 0. Reset is asynchronous and can abort any state.
- Memory returns load data exactly one cycle after O_Ld_Req. LD_WAIT nevertheless tolerates arbitrary latency.
- Store handshake: the write commits on the rising edge where O_St_Req & O_St_FTk.v & ~I_St_BTk.n.
- Unstalled throughput is 3 cycles per element. The first O_Ld_Req rises 1 cycle after boot word 7 is accepted.
- O_St_Req drops the cycle after the final store commits.

## Structure
- Shared package pkg_en holds:
  - WIDTH_DATA and WIDTH_EXADDR.
  - FTk_t as a packed struct {v, a, r, c, i[WIDTH_EXADDR], d[WIDTH_DATA]}. The i field exists only under EXTEND_MEM; it is driven 0.
  - BTk_t as a packed struct {n, t, v, c}.
  - Op encoding constants.
- One natural sub-module: en_boot_cfg, containing the boot word counter and the CFG0..CFG4 registers. The FSM and datapath stay in the top module.

## Test plan
- Copy:
  - Stimulus: memory holds mem[0..4] = {0x100, 0x200, 4, 0x00010001, 0}, mem[0x100..0x103] = {1, 2, 3, 4}. Send the 8-word boot stream.
  - Required: mem[0x200..0x203] = {1, 2, 3, 4}; exactly 4 load and 4 store requests.
- Add immediate:
  - Stimulus: CFG4 = 0xFFFF0001 (imm −1, op 01) on the same data.
  - Required: stores {0, 1, 2, 3}.
- Strides and wrap:
  - Stimulus: CFG3 = 0x00020000 (ststride 2, ldstride 0), N=3, mem[0x100] = 0xFFFFFFFF, op 01, imm 1.
  - Required: mem[0x200], mem[0x202] and mem[0x204] all = 0.
- Backpressure:
  - Stimulus: hold I_St_BTk.n=1 for 5 cycles on the 2nd store.
  - Required: O_St_Addr and O_St_FTk.d stay stable; no write occurs until n=0; no duplicate write.
- N=0:
  - Stimulus: boot with N=0.
  - Required: no O_Ld_Req or O_St_Req; FSM returns to IDLE; a second boot then works normally.
- Reset mid-run:
  - Stimulus: assert reset in ST of element 2.
  - Required: all outputs are 0 immediately; tokens without a are ignored afterwards; a re-boot restarts from k=0.
